msft_dbg_apb_arb: RTL and testbench
===================================

// Module: msft_dbg_apb_arb
// PURPOSE
//  Shares the single debug APB master path (32b addr, 48b data, size-tagged) between NUM_REQ debug
//  requesters (I2C debug sub, UART/JTAG debug bridges). Arbitrates round-robin, re-launches the
//  granted transfer as a clean APB setup/access on the master side, and returns rdata/err.
//  Enforces a bus timeout so a hung target cannot lock out the debug path. Sits between the
//  debug bridges and the 32/16-bit target decode.
// PARAMETERS
//  NUM_REQ      2     number of requester ports (2..4)
//  TIMEOUT_CYC  1024  max ACCESS cycles waiting for m_pready_i; 0 = timeout disabled
// PORTS
//  clk_i          in   1            clock
//  rst_i          in   1            synchronous, active-high reset
//  req_psel_i     in   NUM_REQ      per-requester APB psel
//  req_penable_i  in   NUM_REQ      per-requester APB penable (ignored for arbitration)
//  req_paddr_i    in   NUM_REQ*32   flattened addresses, requester n at [32n+:32]
//  req_pwdata_i   in   NUM_REQ*48   flattened write data, [48n+:48]
//  req_pwrite_i   in   NUM_REQ      write strobe
//  req_size_i     in   NUM_REQ*2    size: 0=byte,1=16b,2=32b,3=48b
//  req_prdata_o   out  48           read data, shared, valid with req_pready_o
//  req_pready_o   out  NUM_REQ      one-hot completion pulse to granted requester
//  req_pslverr_o  out  1            error, valid with req_pready_o
//  m_psel_o, m_penable_o, m_pwrite_o  out 1   master APB controls
//  m_paddr_o      out  32           master address
//  m_pwdata_o     out  48           master write data
//  m_size_o       out  2            size tag forwarded to target decode
//  m_prdata_i     in   48           master read data
//  m_pready_i     in   1            master ready
//  m_pslverr_i    in   1            master error
//  grant_o        out  NUM_REQ      one-hot current owner (0 in IDLE)
//  timeout_o      out  1            one-cycle pulse on a timed-out transfer
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): state IDLE, all outputs 0, rr pointer -> requester 0 highest prio.
//  - FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
//  - IDLE: if any req_psel_i, pick first set bit at/after rr pointer (wrapping); latch its
//    paddr/pwdata/pwrite/size into master regs, set grant_o. No request: stay, outputs 0.
//  - SETUP: m_psel_o=1, m_penable_o=0; counter cleared. Next: ACCESS.
//  - ACCESS: m_psel_o=1, m_penable_o=1. On m_pready_i: capture m_prdata_i (0 on write),
//    m_pslverr_i -> DONE. Else counter++; counter==TIMEOUT_CYC-1 (nonzero param) -> capture
//    prdata=0, err=1, pulse timeout_o, -> DONE. m_pready_i wins over timeout in same cycle.
//  - DONE: m_psel_o/m_penable_o=0; req_pready_o[grant]=1 for exactly this cycle with registered
//    req_prdata_o/req_pslverr_o; rr pointer <- grant+1 mod NUM_REQ; grant_o cleared -> IDLE.
//  - Min latency: psel seen cycle 0 -> m_psel cycle 1 -> m_penable cycle 2 -> req_pready cycle 3.
//  - Master address/data/size stable from SETUP through end of ACCESS (APB rule).
//  - Requester dropping psel mid-transfer: transfer still completes on master side; pready pulse
//    still issued (harmless); no re-arbitration until DONE.
//  - A requester still asserting psel in IDLE right after its DONE re-arbitrates normally; with
//    another requester waiting, rr pointer guarantees the other wins.
//  - req_prdata_o/req_pslverr_o hold last values outside DONE; only pready qualifies them.
//  - Counter width $clog2(TIMEOUT_CYC+1); TIMEOUT_CYC=0 -> wait forever.
//  - rst_i during ACCESS: master psel/penable drop next cycle, no pready pulse issued.
// STRUCTURE
//  - msft_dbg_apb_pkg: arb_state_e {IDLE,SETUP,ACCESS,DONE}; size encodings SZ_8/16/32/48.
//  - Sub-module msft_rr_arb (NUM_REQ req vector + pointer -> one-hot grant), combinational.
//  - Single FSM + master register bank + timeout counter in this module.
// TESTING
//  1 Single write req0: addr 0x1000_0004, data 0x0000_DEADBEEF, size 2, m_pready at 1st ACCESS ->
//    m_psel cycle1, m_penable cycle2, req_pready_o=01 cycle3, pslverr 0.
//  2 Read req1, target waits 5 cycles returning 0x1234_5678_9ABC -> req_prdata_o matches,
//    req_pready_o=10 for one cycle only.
//  3 Both requesters hold psel continuously, 4 transfers -> grants alternate 0,1,0,1.
//  4 TIMEOUT_CYC=8, target never ready -> timeout_o pulse after 8 ACCESS cycles, pslverr=1,
//    prdata=0; next queued request served normally.
//  5 m_pready_i and timeout in same cycle -> normal completion, timeout_o stays 0.
//  6 rst_i asserted mid-ACCESS -> all outputs 0 next cycle, grant_o=0, next grant to req0.

Source files
------------

// File: rtl/msft_dbg_apb_arb_pkg.sv
// Debug APB arbiter shared types.
// FSM states, size tags, rr helper.
package msft_dbg_apb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      DONE
   } arb_state_e;

   typedef enum logic [1:0] {
      SZ_8,
      SZ_16,
      SZ_32,
      SZ_48
   } size_e;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 48;

   // Next round-robin slot after idx, wrapping at n.
   function automatic int rr_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/msft_dbg_apb_arb_if.sv
// Debug APB master-side bus bundle.
// master drives the transfer, slave returns the response.
interface msft_dbg_apb_arb_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [47:0] pwdata;
   logic [1:0]  size;
   logic [47:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, pwrite,
      output paddr, pwdata, size,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite,
      input  paddr, pwdata, size,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/msft_dbg_apb_arb_rr.sv
// Round-robin picker for the debug APB arbiter.
// First request at/after ptr wins, wrapping.
module msft_rr_arb #(
   parameter  int NUM_REQ = 2,
   localparam int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PW-1:0]      gnt_idx,
   output logic               vld
);

   int j;

   // Scan from ptr upward, first hit takes the grant.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      vld     = 1'b0;
      j       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = (int'(ptr) + i) % NUM_REQ;
         if (!vld && req[j]) begin
            vld     = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = PW'(j);
         end
      end
   end

endmodule

// File: rtl/msft_dbg_apb_arb.sv
// Debug APB arbiter: NUM_REQ requesters onto one master.
// Round-robin, clean setup/access relaunch, bus timeout.
module msft_dbg_apb_arb
   import msft_dbg_apb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_REQ-1:0]    req_psel_i,
   input  logic [NUM_REQ-1:0]    req_penable_i,
   input  logic [NUM_REQ*32-1:0] req_paddr_i,
   input  logic [NUM_REQ*48-1:0] req_pwdata_i,
   input  logic [NUM_REQ-1:0]    req_pwrite_i,
   input  logic [NUM_REQ*2-1:0]  req_size_i,
   output logic [47:0]           req_prdata_o,
   output logic [NUM_REQ-1:0]    req_pready_o,
   output logic                  req_pslverr_o,
   msft_dbg_apb_arb_if.master    m_bus,
   output logic [NUM_REQ-1:0]    grant_o,
   output logic                  timeout_o
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int CW =
      (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX =
      CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   arb_state_e        state_q, state_d;
   logic [NUM_REQ-1:0] grant_q;
   logic [PW-1:0]     gidx_q;
   logic [PW-1:0]     ptr_q;
   logic [31:0]       addr_q;
   logic [47:0]       wdata_q;
   logic              write_q;
   size_e             size_q;
   logic [47:0]       rdata_q;
   logic              err_q;
   logic              tmo_q;
   logic [CW-1:0]     cnt_q;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [PW-1:0]     arb_idx;
   logic              arb_vld;
   logic              fin_rdy;
   logic              fin_tmo;
   logic              bus_act;
   logic              unused_penable;

   assign unused_penable = ^req_penable_i;

   msft_rr_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req     (req_psel_i),
      .ptr     (ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .vld     (arb_vld)
   );

   // Next state plus completion/timeout qualifiers.
   always_comb begin
      state_d = state_q;
      fin_rdy = 1'b0;
      fin_tmo = 1'b0;
      unique case (state_q)
         IDLE:   if (arb_vld) state_d = SETUP;
         SETUP:  state_d = ACCESS;
         ACCESS: begin
            if (m_bus.pready) begin
               fin_rdy = 1'b1;
               state_d = DONE;
            end else if (TIMEOUT_CYC != 0 &&
                         cnt_q == CNT_MAX) begin
               fin_tmo = 1'b1;
               state_d = DONE;
            end
         end
         DONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, grant ownership and rr pointer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= fin_tmo;
         if (state_q == IDLE && arb_vld) begin
            grant_q <= arb_gnt;
            gidx_q  <= arb_idx;
         end else if (state_q == DONE) begin
            grant_q <= '0;
            ptr_q   <= PW'(rr_inc(int'(gidx_q), NUM_REQ));
         end
      end
   end

   // Master request bank, latched once at grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         size_q  <= SZ_8;
      end else if (state_q == IDLE && arb_vld) begin
         addr_q  <= req_paddr_i[32*int'(arb_idx) +: 32];
         wdata_q <= req_pwdata_i[48*int'(arb_idx) +: 48];
         write_q <= req_pwrite_i[arb_idx];
         size_q  <= size_e'(req_size_i[2*int'(arb_idx) +: 2]);
      end
   end

   // ACCESS wait counter, cleared in SETUP.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (state_q == SETUP) begin
         cnt_q <= '0;
      end else if (state_q == ACCESS && !m_bus.pready) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Response capture; held until the next completion.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (fin_rdy) begin
         rdata_q <= write_q ? 48'h0 : m_bus.prdata;
         err_q   <= m_bus.pslverr;
      end else if (fin_tmo) begin
         rdata_q <= '0;
         err_q   <= 1'b1;
      end
   end

   assign bus_act = (state_q == SETUP) ||
                    (state_q == ACCESS);

   assign m_bus.psel    = bus_act;
   assign m_bus.penable = (state_q == ACCESS);
   assign m_bus.pwrite  = bus_act & write_q;
   assign m_bus.paddr   = bus_act ? addr_q : '0;
   assign m_bus.pwdata  = bus_act ? wdata_q : '0;
   assign m_bus.size    = bus_act ? size_q : SZ_8;

   assign req_pready_o  =
      (state_q == DONE) ? grant_q : '0;
   assign req_prdata_o  = rdata_q;
   assign req_pslverr_o = err_q;
   assign grant_o       = grant_q;
   assign timeout_o     = tmo_q;

endmodule

// File: tb/tb_msft_dbg_apb_arb.sv
// Self-checking bench for msft_dbg_apb_arb.
// Directed scenarios plus randomized rr traffic.
module tb_msft_dbg_apb_arb;
   import msft_dbg_apb_pkg::*;

   localparam int N  = 2;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    psel = '0;
   logic [N-1:0]    pen  = '0;
   logic [N-1:0]    pwr  = '0;
   logic [N*32-1:0] paddr = '0;
   logic [N*48-1:0] pwdata = '0;
   logic [N*2-1:0]  psize = '0;
   logic [47:0]     prdata;
   logic [N-1:0]    pready;
   logic            perr;
   logic [N-1:0]    grant;
   logic            tmo;

   msft_dbg_apb_arb_if m_if ();

   msft_dbg_apb_arb #(
      .NUM_REQ     (N),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_psel_i    (psel),
      .req_penable_i (pen),
      .req_paddr_i   (paddr),
      .req_pwdata_i  (pwdata),
      .req_pwrite_i  (pwr),
      .req_size_i    (psize),
      .req_prdata_o  (prdata),
      .req_pready_o  (pready),
      .req_pslverr_o (perr),
      .m_bus         (m_if),
      .grant_o       (grant),
      .timeout_o     (tmo)
   );

   // Target model: ready after tgt_wait extra ACCESS cycles, never if <0.
   int          tgt_wait = 0;
   logic [47:0] tgt_rdata = '0;
   logic        tgt_err = 1'b0;
   int          acc_cnt = 0;

   always @(posedge clk)
      if (m_if.psel && m_if.penable && !m_if.pready)
         acc_cnt <= acc_cnt + 1;
      else
         acc_cnt <= 0;

   assign m_if.pready  = m_if.psel && m_if.penable &&
                         tgt_wait >= 0 && acc_cnt == tgt_wait;
   assign m_if.prdata  = m_if.pready ? tgt_rdata : 48'h0;
   assign m_if.pslverr = m_if.pready & tgt_err;

   int n_chk  = 0;
   int n_fail = 0;
   int mptr   = 0;

   logic [31:0] exp_a [N];
   logic [47:0] exp_d [N];
   logic        exp_w [N];
   logic [1:0]  exp_s [N];

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic int pick(input logic [N-1:0] mask, input int ptr);
      for (int k = 0; k < N; k++)
         if (mask[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic set_req(input int r, input logic [31:0] a,
                          input logic [47:0] d, input logic w,
                          input logic [1:0] s);
      paddr[32*r +: 32] = a;
      pwdata[48*r +: 48] = d;
      pwr[r] = w;
      psize[2*r +: 2] = s;
      pen[r] = 1'b1;
      psel[r] = 1'b1;
      exp_a[r] = a;
      exp_d[r] = d;
      exp_w[r] = w;
      exp_s[r] = s;
   endtask

   // Steps until a pready pulse (or limit); returns what was seen.
   task automatic wait_pready(input int limit, output bit seen,
                              output int cyc, output logic [N-1:0] rdy,
                              output logic [47:0] rd, output logic er,
                              output int tcnt, output bit stable);
      logic [31:0] a0;
      logic [47:0] d0;
      a0 = m_if.paddr;
      d0 = m_if.pwdata;
      seen = 0; cyc = 0; rdy = '0; rd = '0; er = 0;
      tcnt = 0; stable = 1;
      for (int i = 0; i < limit; i++) begin
         step;
         cyc++;
         if (tmo) tcnt++;
         if (m_if.psel && (m_if.paddr !== a0 || m_if.pwdata !== d0))
            stable = 0;
         if (pready != '0) begin
            seen = 1; rdy = pready; rd = prdata; er = perr;
            break;
         end
      end
   endtask

   task automatic wait_grant;
      for (int i = 0; i < 6; i++) begin
         step;
         if (grant != '0) break;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step; step;
      n_chk++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got=%b exp=00", grant); end
      n_chk++; if (m_if.psel !== 1'b0 || m_if.penable !== 1'b0) begin n_fail++; $display("FAIL reset_bus got=%b%b exp=00", m_if.psel, m_if.penable); end
      n_chk++; if (pready !== 2'b00 || tmo !== 1'b0) begin n_fail++; $display("FAIL reset_pready got=%b/%b exp=00/0", pready, tmo); end
      n_chk++; if (prdata !== 48'h0 || perr !== 1'b0 || m_if.paddr !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h/%b/%h exp=0", prdata, perr, m_if.paddr); end
      rst = 1'b0;
      mptr = 0;
   endtask

   task automatic test_single_write;
      tgt_wait = 0; tgt_err = 0; tgt_rdata = 48'hFFFF_FFFF_FFFF;
      set_req(0, 32'h1000_0004, 48'h0000_DEADBEEF, 1'b1, 2'd2);
      step;
      n_chk++; if (m_if.psel !== 1'b1 || m_if.penable !== 1'b0 || grant !== 2'b01) begin n_fail++; $display("FAIL wr_setup got psel=%b pen=%b gnt=%b exp=1 0 01", m_if.psel, m_if.penable, grant); end
      n_chk++; if (m_if.paddr !== 32'h1000_0004 || m_if.pwdata !== 48'hDEADBEEF || m_if.pwrite !== 1'b1 || m_if.size !== 2'd2) begin n_fail++; $display("FAIL wr_payload got=%h/%h/%b/%0d", m_if.paddr, m_if.pwdata, m_if.pwrite, m_if.size); end
      step;
      n_chk++; if (m_if.psel !== 1'b1 || m_if.penable !== 1'b1) begin n_fail++; $display("FAIL wr_access got=%b%b exp=11", m_if.psel, m_if.penable); end
      step;
      n_chk++; if (pready !== 2'b01 || perr !== 1'b0 || tmo !== 1'b0 || prdata !== 48'h0) begin n_fail++; $display("FAIL wr_done got=%b/%b/%b/%h exp=01/0/0/0", pready, perr, tmo, prdata); end
      n_chk++; if (m_if.psel !== 1'b0) begin n_fail++; $display("FAIL wr_done_psel got=%b exp=0", m_if.psel); end
      psel[0] = 1'b0;
      step;
      n_chk++; if (pready !== 2'b00 || grant !== 2'b00) begin n_fail++; $display("FAIL wr_idle got=%b/%b exp=00/00", pready, grant); end
      mptr = 1;
   endtask

   task automatic test_read_wait;
      bit seen, stb; int cyc, tc; logic [N-1:0] rdy; logic [47:0] rd; logic er;
      tgt_wait = 5; tgt_rdata = 48'h1234_5678_9ABC; tgt_err = 0;
      set_req(1, 32'h2000_0010, 48'h0, 1'b0, 2'd3);
      step;
      n_chk++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rd_grant got=%b exp=10", grant); end
      wait_pready(20, seen, cyc, rdy, rd, er, tc, stb);
      n_chk++; if (!seen || cyc != 7) begin n_fail++; $display("FAIL rd_latency got=%0d/%0d exp=1/7", seen, cyc); end
      n_chk++; if (rdy !== 2'b10 || rd !== 48'h1234_5678_9ABC || er !== 1'b0) begin n_fail++; $display("FAIL rd_data got=%b/%h/%b", rdy, rd, er); end
      n_chk++; if (!stb) begin n_fail++; $display("FAIL rd_stable got=0 exp=1"); end
      psel[1] = 1'b0;
      step;
      n_chk++; if (pready !== 2'b00 || prdata !== 48'h1234_5678_9ABC) begin n_fail++; $display("FAIL rd_pulse got=%b/%h exp=00/held", pready, prdata); end
      mptr = 0;
   endtask

   task automatic test_round_robin;
      bit seen, stb; int cyc, tc, e; logic [N-1:0] rdy; logic [47:0] rd; logic er;
      tgt_err = 0;
      set_req(0, 32'hA000_0000, 48'h11, 1'b0, 2'd1);
      set_req(1, 32'hB000_0000, 48'h22, 1'b0, 2'd0);
      for (int t = 0; t < 4; t++) begin
         tgt_wait = int'($urandom_range(0, 2));
         tgt_rdata = {16'(t), $urandom};
         e = pick(2'b11, mptr);
         wait_grant;
         n_chk++; if (grant !== 2'(1 << e) || e != t % 2) begin n_fail++; $display("FAIL rr_grant t=%0d got=%b exp=%b", t, grant, 2'(1 << (t % 2))); end
         n_chk++; if (m_if.paddr !== exp_a[t % 2]) begin n_fail++; $display("FAIL rr_addr got=%h exp=%h", m_if.paddr, exp_a[t % 2]); end
         wait_pready(10, seen, cyc, rdy, rd, er, tc, stb);
         n_chk++; if (!seen || rdy !== 2'(1 << e) || rd !== tgt_rdata) begin n_fail++; $display("FAIL rr_done got=%0d/%b/%h exp=1/%b/%h", seen, rdy, rd, 2'(1 << e), tgt_rdata); end
         mptr = (e + 1) % N;
      end
      psel = '0;
      step;
   endtask

   task automatic test_timeout;
      bit seen, stb; int cyc, tc; logic [N-1:0] rdy; logic [47:0] rd; logic er;
      tgt_wait = -1; tgt_rdata = 48'hAAAA_BBBB_CCCC; tgt_err = 0;
      set_req(0, 32'h3000_0000, 48'h0, 1'b0, 2'd2);
      set_req(1, 32'h3000_0100, 48'h0, 1'b0, 2'd2);
      step;
      n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL to_grant got=%b exp=01", grant); end
      wait_pready(30, seen, cyc, rdy, rd, er, tc, stb);
      n_chk++; if (!seen || cyc != TO + 1) begin n_fail++; $display("FAIL to_latency got=%0d/%0d exp=1/%0d", seen, cyc, TO + 1); end
      n_chk++; if (rdy !== 2'b01 || er !== 1'b1 || rd !== 48'h0) begin n_fail++; $display("FAIL to_resp got=%b/%b/%h exp=01/1/0", rdy, er, rd); end
      n_chk++; if (tc != 1 || tmo !== 1'b1) begin n_fail++; $display("FAIL to_pulse got=%0d/%b exp=1/1", tc, tmo); end
      psel[0] = 1'b0;
      mptr = 1;
      tgt_wait = 1; tgt_rdata = 48'h0102_0304_0506;
      wait_grant;
      n_chk++; if (grant !== 2'b10) begin n_fail++; $display("FAIL to_next_grant got=%b exp=10", grant); end
      wait_pready(10, seen, cyc, rdy, rd, er, tc, stb);
      n_chk++; if (!seen || rdy !== 2'b10 || rd !== 48'h0102_0304_0506 || er !== 1'b0 || tc != 0) begin n_fail++; $display("FAIL to_next_done got=%0d/%b/%h/%b/%0d", seen, rdy, rd, er, tc); end
      psel = '0;
      mptr = 0;
      step;
   endtask

   task automatic test_ready_vs_timeout;
      bit seen, stb; int cyc, tc; logic [N-1:0] rdy; logic [47:0] rd; logic er;
      tgt_wait = TO - 1; tgt_rdata = 48'h5555_6666_7777; tgt_err = 0;
      set_req(0, 32'h4000_0000, 48'h0, 1'b0, 2'd3);
      step;
      wait_pready(30, seen, cyc, rdy, rd, er, tc, stb);
      n_chk++; if (!seen || cyc != TO + 1 || rdy !== 2'b01) begin n_fail++; $display("FAIL race_latency got=%0d/%0d/%b exp=1/%0d/01", seen, cyc, rdy, TO + 1); end
      n_chk++; if (rd !== 48'h5555_6666_7777 || er !== 1'b0 || tc != 0) begin n_fail++; $display("FAIL race_resp got=%h/%b/%0d exp=555566667777/0/0", rd, er, tc); end
      psel = '0;
      mptr = 1;
      step;
   endtask

   task automatic test_reset_mid_access;
      bit seen, stb; int cyc, tc; logic [N-1:0] rdy; logic [47:0] rd; logic er;
      tgt_wait = -1; tgt_err = 0;
      set_req(1, 32'h5000_0000, 48'h77, 1'b1, 2'd0);
      step;
      n_chk++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rst_pre_grant got=%b exp=10", grant); end
      step; step; step;
      set_req(0, 32'h5000_0040, 48'h0, 1'b0, 2'd1);
      rst = 1'b1;
      step;
      n_chk++; if (m_if.psel !== 1'b0 || m_if.penable !== 1'b0 || grant !== 2'b00 || pready !== 2'b00 || tmo !== 1'b0) begin n_fail++; $display("FAIL rst_mid got=%b%b/%b/%b/%b exp=0", m_if.psel, m_if.penable, grant, pready, tmo); end
      rst = 1'b0;
      mptr = 0;
      tgt_wait = 0; tgt_rdata = 48'h0000_0000_BEEF;
      step;
      n_chk++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rst_next_grant got=%b exp=01", grant); end
      wait_pready(10, seen, cyc, rdy, rd, er, tc, stb);
      n_chk++; if (!seen || rdy !== 2'b01 || rd !== 48'hBEEF) begin n_fail++; $display("FAIL rst_next_done got=%0d/%b/%h", seen, rdy, rd); end
      psel[0] = 1'b0;
      mptr = 1;
      wait_grant;
      wait_pready(10, seen, cyc, rdy, rd, er, tc, stb);
      n_chk++; if (!seen || rdy !== 2'b10 || rd !== 48'h0) begin n_fail++; $display("FAIL rst_req1_done got=%0d/%b/%h", seen, rdy, rd); end
      psel = '0;
      mptr = 0;
      step;
   endtask

   task automatic test_random;
      bit seen, stb; int cyc, tc, e; logic [N-1:0] rdy, mask;
      logic [47:0] rd, want; logic er;
      for (int it = 0; it < 40; it++) begin
         mask = N'($urandom_range(1, 3));
         for (int r = 0; r < N; r++)
            if (mask[r])
               set_req(r, $urandom, {16'($urandom), $urandom},
                       1'($urandom), 2'($urandom));
         tgt_wait = int'($urandom_range(0, 3));
         tgt_rdata = {16'($urandom), $urandom};
         tgt_err = 1'($urandom);
         e = pick(mask, mptr);
         wait_grant;
         n_chk++; if (grant !== 2'(1 << e)) begin n_fail++; $display("FAIL rnd_grant it=%0d got=%b exp=%b", it, grant, 2'(1 << e)); end
         n_chk++; if (m_if.paddr !== exp_a[e] || m_if.pwdata !== exp_d[e] || m_if.pwrite !== exp_w[e] || m_if.size !== exp_s[e]) begin n_fail++; $display("FAIL rnd_payload it=%0d got=%h/%h exp=%h/%h", it, m_if.paddr, m_if.pwdata, exp_a[e], exp_d[e]); end
         if ($urandom_range(0, 1) == 1) psel[e] = 1'b0;
         wait_pready(10, seen, cyc, rdy, rd, er, tc, stb);
         want = exp_w[e] ? 48'h0 : tgt_rdata;
         n_chk++; if (!seen || rdy !== 2'(1 << e) || rd !== want || er !== tgt_err || !stb || cyc != tgt_wait + 2) begin n_fail++; $display("FAIL rnd_done it=%0d got=%0d/%b/%h/%b/%0d exp=1/%b/%h/%b/%0d", it, seen, rdy, rd, er, cyc, 2'(1 << e), want, tgt_err, tgt_wait + 2); end
         psel = '0;
         mptr = (e + 1) % N;
         step;
      end
   endtask

   initial begin
      test_reset;
      test_single_write;
      test_read_wait;
      test_round_robin;
      test_timeout;
      test_ready_vs_timeout;
      test_reset_mid_access;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
